// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, [Z,C,N,V] flag register
// and an iterative shift-add multiplier (one partial product per cycle).
`default_nettype none

module alu_seq #(
  parameter int  WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  input  logic [4:0]       uop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_wb,
  output logic             out_err,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [4:0] OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_CMP = 5'd5,  OP_LSL = 5'd6,  OP_LSR = 5'd7;
  localparam logic [4:0] OP_MOV = 5'd8,  OP_ORR = 5'd9,  OP_ASR = 5'd10, OP_ROR = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd12;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] out_q, mul_a_q, mul_b_q, mul_acc_q;
  logic             out_valid_q, wb_q, err_q;
  logic [3:0]       flags_q;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH-1:0] res_d;
  logic             wb_d, err_d, zn_d;
  logic [3:0]       flags_d;

  logic             accept, is_mul, mul_last;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     ror_amt;
  logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH-1:0] ror_w, acc_step;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (uop == OP_MUL);
  assign mul_last  = (state_q == S_MUL) && (&cnt_q);
  assign acc_step  = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

  // Shifts carry one extra bit so the last bit shifted out lands in a fixed slot.
  assign sh      = RHS[SHW-1:0];
  assign ror_amt = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign add_w   = {1'b0, LHS} + {1'b0, RHS};
  assign sub_w   = {1'b0, LHS} - {1'b0, RHS};
  assign lsl_w   = {1'b0, LHS} << sh;
  assign lsr_w   = {LHS, 1'b0} >> sh;
  assign asr_w   = $signed({LHS, 1'b0}) >>> sh;
  assign ror_w   = (LHS >> sh) | (LHS << ror_amt);

  always_comb begin
    res_d   = '0;
    wb_d    = 1'b1;
    err_d   = 1'b0;
    zn_d    = 1'b1;
    flags_d = flags_q;
    case (uop)
      OP_NOP: begin wb_d = 1'b0; zn_d = 1'b0; end
      OP_ADD: begin
        res_d      = add_w[WIDTH-1:0];
        flags_d[2] = add_w[WIDTH];
        flags_d[0] = (LHS[WIDTH-1] == RHS[WIDTH-1]) && (add_w[WIDTH-1] != LHS[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_d      = sub_w[WIDTH-1:0];
        flags_d[2] = !sub_w[WIDTH];
        flags_d[0] = (LHS[WIDTH-1] != RHS[WIDTH-1]) && (sub_w[WIDTH-1] != LHS[WIDTH-1]);
        wb_d       = (uop == OP_SUB);
      end
      OP_AND: res_d = LHS & RHS;
      OP_XOR: res_d = LHS ^ RHS;
      OP_ORR: res_d = LHS | RHS;
      OP_MOV: res_d = RHS;
      OP_LSL: begin
        res_d = lsl_w[WIDTH-1:0];
        if (sh != '0) flags_d[2] = lsl_w[WIDTH];
      end
      OP_LSR: begin
        res_d = lsr_w[WIDTH:1];
        if (sh != '0) flags_d[2] = lsr_w[0];
      end
      OP_ASR: begin
        res_d = asr_w[WIDTH:1];
        if (sh != '0) flags_d[2] = asr_w[0];
      end
      OP_ROR: begin
        res_d = ror_w;
        if (sh != '0) flags_d[2] = ror_w[WIDTH-1];
      end
      default: begin wb_d = 1'b0; err_d = 1'b1; zn_d = 1'b0; end
    endcase
    if (zn_d) begin
      flags_d[3] = (res_d == '0);
      flags_d[1] = res_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wb_q        <= 1'b0;
      err_q       <= 1'b0;
      flags_q     <= 4'b0000;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_acc_q   <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept && is_mul) begin
          state_q   <= S_MUL;
          mul_a_q   <= LHS;
          mul_b_q   <= RHS;
          mul_acc_q <= '0;
          cnt_q     <= '0;
        end
        S_MUL: begin
          mul_acc_q <= acc_step;
          mul_a_q   <= mul_a_q << 1;
          mul_b_q   <= mul_b_q >> 1;
          cnt_q     <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept && !is_mul) begin
        out_q       <= res_d;
        wb_q        <= wb_d;
        err_q       <= err_d;
        flags_q     <= flags_d;
        out_valid_q <= 1'b1;
      end else if (mul_last) begin
        out_q       <= acc_step;
        wb_q        <= 1'b1;
        err_q       <= 1'b0;
        flags_q[3]  <= (acc_step == '0);
        flags_q[1]  <= acc_step[WIDTH-1];
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_wb    = wb_q;
  assign out_err   = err_q;
  assign flags     = flags_q;
  assign busy      = (state_q == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=32.
`default_nettype none

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        out_wb, out_err, busy;
  logic [31:0] LHS, RHS, out;
  logic [4:0]  uop;
  logic [3:0]  flags;
  int          n_cmp = 0;
  int          n_mis = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .LHS(LHS), .RHS(RHS), .uop(uop), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_wb(out_wb), .out_err(out_err), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op at the falling edge; returns #1 after the accepting rising edge.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] l, input logic [31:0] r);
    @(negedge clk);
    uop = op; LHS = l; RHS = r; in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] e_out, input logic [3:0] e_flags, input logic e_wb);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"},   out, e_out);
    chk({tag, "_flags"}, 32'(flags), 32'(e_flags));
    chk({tag, "_wb"},    32'(out_wb), 32'(e_wb));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    LHS = '0; RHS = '0; uop = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out",   out, 32'd0);
    chk("rst_wb",    32'(out_wb), 32'd0);
    chk("rst_err",   32'(out_err), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Arithmetic and compare
    do_op("add1", 5'd1, 32'h0000_0000, 32'h0000_0001); chk_res("add1", 32'h0000_0001, 4'b0000, 1'b1);
    do_op("add2", 5'd1, 32'hFFFF_FFFF, 32'h0000_0001); chk_res("add2", 32'h0000_0000, 4'b1100, 1'b1);
    do_op("cmp",  5'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF); chk_res("cmp",  32'h8000_0000, 4'b0011, 1'b0);
    do_op("sub",  5'd2, 32'h0000_0001, 32'h0000_0001); chk_res("sub",  32'h0000_0000, 4'b1100, 1'b1);

    // Shifts and rotate; s=0 leaves C alone
    do_op("lsr",  5'd7,  32'h8000_0000, 32'd1);  chk_res("lsr",  32'h4000_0000, 4'b0000, 1'b1);
    do_op("lsl",  5'd6,  32'h8000_0000, 32'd1);  chk_res("lsl",  32'h0000_0000, 4'b1100, 1'b1);
    do_op("asr",  5'd10, 32'h8000_0000, 32'd31); chk_res("asr",  32'hFFFF_FFFF, 4'b0010, 1'b1);
    do_op("ror",  5'd11, 32'h0000_0001, 32'd1);  chk_res("ror",  32'h8000_0000, 4'b0110, 1'b1);
    do_op("lsl0", 5'd6,  32'h1234_5678, 32'd32); chk_res("lsl0", 32'h1234_5678, 4'b0100, 1'b1);
    do_op("mov",  5'd8,  32'h0,         32'h8000_0001); chk_res("mov", 32'h8000_0001, 4'b0110, 1'b1);

    // Multi-cycle multiply with operands changed after acceptance
    do_op("mul", 5'd12, 32'h0000_FFFF, 32'h0001_0001);
    LHS = 32'h1234_0000; RHS = 32'h0000_0003; uop = 5'd1;
    chk("mul_busy0", 32'(busy), 32'd1);
    chk("mul_rdy0",  32'(in_ready), 32'd0);
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      chk("mul_busy",  32'(busy), 32'd1);
      chk("mul_rdy",   32'(in_ready), 32'd0);
      chk("mul_early", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("mul_busy_end", 32'(busy), 32'd0);
    chk_res("mul", 32'hFFFF_FFFF, 4'b0110, 1'b1);

    // Backpressure: result held, pending op waits, then issues same cycle
    do_op("and", 5'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    out_ready = 1'b0;
    uop = 5'd4; LHS = 32'h0F0F_0F0F; RHS = 32'hFFFF_FFFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_out",   out, 32'd0);
      chk("bp_flags", 32'(flags), 32'b1100);
      chk("bp_rdy",   32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    #1 chk("bp_rdy_up", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk_res("bp_xor", 32'hF0F0_F0F0, 4'b0110, 1'b1);

    // Asynchronous reset during a multiply
    do_op("mul2", 5'd12, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_flags", 32'(flags), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("arst_rdy", 32'(in_ready), 32'd1);
    do_op("xor", 5'd4, 32'hAAAA_AAAA, 32'h5555_5555); chk_res("xor", 32'hFFFF_FFFF, 4'b0010, 1'b1);
    repeat (35) @(posedge clk);
    #1 chk("no_ghost_mul", 32'(out_valid), 32'd0);

    // Illegal and NOP
    do_op("ill", 5'd20, 32'h1111_1111, 32'h2222_2222);
    chk_res("ill", 32'd0, 4'b0010, 1'b0);
    chk("ill_err", 32'(out_err), 32'd1);
    do_op("nop", 5'd0, 32'h1111_1111, 32'h2222_2222);
    chk_res("nop", 32'd0, 4'b0010, 1'b0);
    chk("nop_err", 32'(out_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
